// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready handshake bundle for the sequential InvSubBytes engine.
// The master drives a state in and takes the result; the slave is the engine.
interface inv_sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: LANES inverse S-box lookups per cycle over a
// 128-bit working register, so a full state takes 16/LANES busy cycles.
module inv_sub_bytes_seq #(
  parameter int LANES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  inv_sub_bytes_seq_if.slave   bus
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [3:0] IDX_STEP = 4'(LANES);
  localparam logic [3:0] LAST_IDX = 4'(16 - LANES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [127:0]         w_q, w_d;
  logic [3:0]           idx_q, idx_d;
  logic [6:0]           base;
  logic [8*LANES-1:0]   grp_in;
  logic [8*LANES-1:0]   grp_out;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and conveniently maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Byte idx sits at bit 127-8*idx; the group is LANES bytes starting there.
  assign base   = {idx_q, 3'b000};
  assign grp_in = w_q[7'd127 - base -: 8*LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign grp_out[8*(LANES-gi)-1 -: 8] = inv_sbox(grp_in[8*(LANES-gi)-1 -: 8]);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          w_d     = bus.in_state;
          idx_d   = 4'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        w_d[7'd127 - base -: 8*LANES] = grp_out;
        idx_d = idx_q + IDX_STEP;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= 128'h0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = w_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: one instance per legal LANES value,
// checked against a hand-entered forward S-box and hand-computed vectors.
module tb_inv_sub_bytes_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]   in_valid_a;
  logic [4:0]   out_ready_a;
  logic [127:0] in_state_a [5];
  wire  [4:0]   in_ready_a;
  wire  [4:0]   out_valid_a;
  wire  [127:0] out_state_a [5];

  int n_checks = 0;
  int n_fail   = 0;

  // Forward AES S-box, entry x at index x.
  logic [0:255][7:0] sbox_fwd = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_dut
      inv_sub_bytes_seq_if bus_if ();
      assign bus_if.in_valid  = in_valid_a[gi];
      assign bus_if.in_state  = in_state_a[gi];
      assign bus_if.out_ready = out_ready_a[gi];
      assign in_ready_a[gi]   = bus_if.in_ready;
      assign out_valid_a[gi]  = bus_if.out_valid;
      assign out_state_a[gi]  = bus_if.out_state;
      inv_sub_bytes_seq #(.LANES(1 << gi)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
      );
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on instance d; bp = cycles of out_ready low after out_valid,
  // noise = keep in_valid high and scramble in_state while the engine is busy/done.
  task automatic run_vec(input int d, input logic [127:0] s, input logic [127:0] exp,
                         input int bp, input bit noise);
    int lat;
    logic [127:0] held;
    @(negedge clk);
    check_eq("in_ready_idle", 128'(in_ready_a[d]), 128'd1);
    in_valid_a[d]  = 1'b1;
    in_state_a[d]  = s;
    out_ready_a[d] = (bp == 0);
    @(posedge clk); #1;
    if (noise) in_state_a[d] = ~s;
    else       in_valid_a[d] = 1'b0;
    lat = 0;
    while (out_valid_a[d] !== 1'b1 && lat < 40) begin
      if (noise) check_eq("in_ready_busy", 128'(in_ready_a[d]), 128'd0);
      @(posedge clk); #1;
      lat++;
    end
    $display("lanes=%0d in=%h out=%h latency=%0d", 1 << d, s, out_state_a[d], lat);
    check_eq("latency", 128'(lat), 128'(16 >> d));
    check_eq("result", out_state_a[d], exp);
    held = out_state_a[d];
    for (int i = 0; i < bp; i++) begin
      if (noise) in_state_a[d] = s ^ 128'(i + 1);
      @(posedge clk); #1;
      check_eq("bp_valid", 128'(out_valid_a[d]), 128'd1);
      check_eq("bp_state", out_state_a[d], held);
      check_eq("bp_in_ready", 128'(in_ready_a[d]), 128'd0);
    end
    in_valid_a[d]  = 1'b0;
    out_ready_a[d] = 1'b1;
    @(posedge clk); #1;
    check_eq("xfer_valid", 128'(out_valid_a[d]), 128'd0);
    check_eq("xfer_in_ready", 128'(in_ready_a[d]), 128'd1);
  endtask

  localparam logic [127:0] VEC_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_OUT = 128'h52096ad53036a538bf40a39e81f3d7fb;

  initial begin
    logic [127:0] s, e;
    logic [127:0] b2b_in  [3];
    logic [127:0] b2b_exp [3];
    int acc_cyc [3];
    int cyc, nacc, nout;
    bit acc_now;

    rst = 1'b1;
    in_valid_a  = '0;
    out_ready_a = '0;
    for (int d = 0; d < 5; d++) in_state_a[d] = 128'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 5; d++) begin
      check_eq("rst_in_ready", 128'(in_ready_a[d]), 128'd1);
      check_eq("rst_out_valid", 128'(out_valid_a[d]), 128'd0);
      check_eq("rst_out_state", out_state_a[d], 128'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Reference vector, plain and with input noise during busy/done
    run_vec(0, VEC_IN, VEC_OUT, 0, 1'b0);
    run_vec(0, VEC_IN, VEC_OUT, 3, 1'b1);
    run_vec(0, {16{8'h63}}, 128'h0, 0, 1'b0);
    run_vec(0, {16{8'h16}}, {16{8'hff}}, 0, 1'b0);
    run_vec(0, {16{8'hed}}, {16{8'h53}}, 0, 1'b0);

    // Backpressure: 10 cycles of out_ready low
    run_vec(0, VEC_IN, VEC_OUT, 10, 1'b0);
    run_vec(2, VEC_IN, VEC_OUT, 10, 1'b0);

    // Round trip over all 256 bytes for every LANES value
    for (int d = 0; d < 5; d++) begin
      for (int j = 0; j < 16; j++) begin
        for (int i = 0; i < 16; i++) begin
          s[127 - 8*i -: 8] = sbox_fwd[16*j + i];
          e[127 - 8*i -: 8] = 8'(16*j + i);
        end
        run_vec(d, s, e, 0, 1'b0);
      end
    end

    // Asynchronous reset in BUSY cycle 7 of a LANES=1 operation
    @(negedge clk);
    in_valid_a[0]  = 1'b1;
    in_state_a[0]  = VEC_IN;
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", 128'(out_valid_a[0]), 128'd0);
    check_eq("midrst_out_state", out_state_a[0], 128'h0);
    check_eq("midrst_in_ready", 128'(in_ready_a[0]), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    run_vec(0, {16{8'h7c}}, {16{8'h01}}, 0, 1'b0);

    // LANES=16 back-to-back with in_valid and out_ready held high
    b2b_in[0] = VEC_IN;       b2b_exp[0] = VEC_OUT;
    b2b_in[1] = {16{8'h63}};  b2b_exp[1] = 128'h0;
    b2b_in[2] = {16{8'h16}};  b2b_exp[2] = {16{8'hff}};
    cyc = 0; nacc = 0; nout = 0;
    @(negedge clk);
    in_state_a[4]  = b2b_in[0];
    in_valid_a[4]  = 1'b1;
    out_ready_a[4] = 1'b1;
    while (nout < 3 && cyc < 30) begin
      @(negedge clk);
      if (nacc >= 3) in_valid_a[4] = 1'b0;
      acc_now = in_ready_a[4] && in_valid_a[4];
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc < 3) in_state_a[4] = b2b_in[nacc];
      end
      if (out_valid_a[4] === 1'b1 && nout < nacc) begin
        $display("b2b result %0d out=%h cycle=%0d", nout, out_state_a[4], cyc);
        check_eq("b2b_result", out_state_a[4], b2b_exp[nout]);
        check_eq("b2b_latency", 128'(cyc - acc_cyc[nout]), 128'd1);
        if (nout > 0) check_eq("b2b_spacing", 128'(acc_cyc[nout] - acc_cyc[nout-1]), 128'd3);
        nout++;
      end
    end
    in_valid_a[4] = 1'b0;
    check_eq("b2b_count", 128'(nout), 128'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
